// File: rtl/vga_tile_buffer_if.sv
// Bus-side port bundle of vga_tile_buffer: byte-strobed writes and requested reads.
// Suffixes _i/_o are from the tile buffer's point of view (slave modport).
interface vga_tile_buffer_if #(
    parameter int DATA_W = 28,
    parameter int ADDR_W = 10,
    parameter int BUS_W  = 32
);
    localparam int STRB_W = BUS_W / 8;

    logic              wr_en_i;
    logic [ADDR_W-1:0] w_addr_i;
    logic [STRB_W-1:0] w_strb_i;
    logic [DATA_W-1:0] din_i;
    logic              r_req_i;
    logic [ADDR_W-1:0] r_addr_i;
    logic [BUS_W-1:0]  r_data_o;
    logic              r_valid_o;

    modport master (
        output wr_en_i, w_addr_i, w_strb_i, din_i, r_req_i, r_addr_i,
        input  r_data_o, r_valid_o
    );

    modport slave (
        input  wr_en_i, w_addr_i, w_strb_i, din_i, r_req_i, r_addr_i,
        output r_data_o, r_valid_o
    );
endinterface

// File: rtl/vga_tile_buffer.sv
// Tile buffer with a 1-cycle video read port, byte-strobed bus port and a clear-on-reset FSM.
// Define VGA_BUF_DOUBLE_EN for two pages: video reads page_o, the bus works on the other one.
module vga_tile_buffer #(
    parameter int DATA_W = 28,
    parameter int DEPTH  = 600,
    parameter int ADDR_W = 10,
    parameter int BUS_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    vga_tile_buffer_if.slave  bus,
    input  logic [ADDR_W-1:0] vr_addr_i,
    output logic [DATA_W-1:0] dout_o,
    input  logic              swap_req_i,
    input  logic              frame_start_i,
    output logic              swap_pending_o,
    output logic              page_o,
    output logic              busy_o,
    output logic              dbg_state_o
);
`ifdef VGA_BUF_DOUBLE_EN
    localparam int PAGES = 2;
`else
    localparam int PAGES = 1;
`endif
    localparam int STRB_W = BUS_W / 8;
    localparam int NB     = (DATA_W + 7) / 8;
    localparam int IDX_W  = (PAGES * DEPTH > 1) ? $clog2(PAGES * DEPTH) : 1;
    localparam logic [IDX_W-1:0]  DEPTH_I = IDX_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [BUS_W-1:0]  r_data_q, r_data_d;
    logic              r_valid_q, r_valid_d;
    logic              page_q, page_d;
    logic              pend_q, pend_d;

    logic [DATA_W-1:0] mem_q [PAGES*DEPTH];

    logic              vid_page, bus_page;
    logic              w_ok, v_ok, r_ok;
    logic [IDX_W-1:0]  w_idx, v_idx, r_idx;
    logic [DATA_W-1:0] w_data, w_mask;
    logic [NB*8-1:0]   strb_mask;
    logic              unused_bits;

    for (genvar k = 0; k < NB; k++) begin : g_mask
        assign strb_mask[k*8 +: 8] = {8{bus.w_strb_i[k]}};
    end
    assign w_mask = strb_mask[DATA_W-1:0];

`ifdef VGA_BUF_DOUBLE_EN
    assign vid_page = page_q;
    assign bus_page = ~page_q;
    // A swap takes effect only on a frame boundary, so video never tears mid-frame.
    always_comb begin
        page_d = page_q;
        pend_d = pend_q;
        if (frame_start_i && (pend_q || swap_req_i)) begin
            page_d = ~page_q;
            pend_d = 1'b0;
        end else if (swap_req_i) begin
            pend_d = 1'b1;
        end
    end
    assign unused_bits = ^{strb_mask, bus.w_strb_i};
`else
    assign vid_page = 1'b0;
    assign bus_page = 1'b0;
    assign page_d   = 1'b0;
    assign pend_d   = 1'b0;
    assign unused_bits = ^{strb_mask, bus.w_strb_i, swap_req_i, frame_start_i, page_q, pend_q};
`endif

    // Out-of-range addresses are steered to index 0 and masked by their *_ok flag.
    always_comb begin
        w_ok  = !busy_q && bus.wr_en_i && (32'(bus.w_addr_i) < DEPTH);
        v_ok  = 32'(vr_addr_i) < DEPTH;
        r_ok  = 32'(bus.r_addr_i) < DEPTH;
        w_idx = w_ok ? ((bus_page ? DEPTH_I : '0) + IDX_W'(bus.w_addr_i)) : '0;
        v_idx = v_ok ? ((vid_page ? DEPTH_I : '0) + IDX_W'(vr_addr_i)) : '0;
        r_idx = r_ok ? ((bus_page ? DEPTH_I : '0) + IDX_W'(bus.r_addr_i)) : '0;
        w_data = (mem_q[w_idx] & ~w_mask) | (bus.din_i & w_mask);
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            if (clr_addr_q == LAST_A) begin
                state_d    = ST_IDLE;
                clr_addr_d = '0;
            end else begin
                clr_addr_d = clr_addr_q + 1'b1;
            end
        end
        busy_d = (state_d == ST_CLEAR);
    end

    // Bus reads: r_req_i is a one-cycle request with no backpressure; r_valid_o pulses
    // the following cycle and r_data_o then holds until the next request.
    always_comb begin
        dout_d    = (!busy_q && v_ok) ? mem_q[v_idx] : '0;
        r_valid_d = bus.r_req_i;
        r_data_d  = r_data_q;
        if (bus.r_req_i) begin
            r_data_d = (!busy_q && r_ok) ? BUS_W'(mem_q[r_idx]) : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
            dout_q     <= '0;
            r_data_q   <= '0;
            r_valid_q  <= 1'b0;
            page_q     <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
            dout_q     <= dout_d;
            r_data_q   <= r_data_d;
            r_valid_q  <= r_valid_d;
            page_q     <= page_d;
            pend_q     <= pend_d;
        end
    end

    // Storage has no reset; the CLEAR sweep zeroes every page at the same offset each cycle.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            for (int p = 0; p < PAGES; p++) begin
                mem_q[((p == 1) ? DEPTH_I : '0) + IDX_W'(clr_addr_q)] <= '0;
            end
        end else if (w_ok) begin
            mem_q[w_idx] <= w_data;
        end
    end

    assign dout_o         = dout_q;
    assign bus.r_data_o   = r_data_q;
    assign bus.r_valid_o  = r_valid_q;
    assign page_o         = page_q;
    assign swap_pending_o = pend_q;
    assign busy_o         = busy_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_vga_tile_buffer.sv
// Self-checking bench for vga_tile_buffer: reference model of the pages, bus-read scoreboard,
// strobe vector table and hand sequences for clear, reset restart, same-edge access and swap.
module tb_vga_tile_buffer;
    localparam int DATA_W = 28;
    localparam int DEPTH  = 600;
    localparam int ADDR_W = 10;
    localparam int BUS_W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] vr_addr = '0;
    logic [DATA_W-1:0] dout;
    logic              swap_req = 1'b0;
    logic              frame_start = 1'b0;
    logic              swap_pending, page, busy, dbg_state;

    vga_tile_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUS_W(BUS_W)) bus_if ();

    vga_tile_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUS_W(BUS_W)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus_if), .vr_addr_i(vr_addr), .dout_o(dout),
        .swap_req_i(swap_req), .frame_start_i(frame_start), .swap_pending_o(swap_pending),
        .page_o(page), .busy_o(busy), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [BUS_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] model [2][DEPTH];
    logic              page_exp = 1'b0;
    logic              pend_exp = 1'b0;

    typedef struct {
        int                addr;
        logic [DATA_W-1:0] data;
        logic [3:0]        strb;
        int                rd_addr;
        logic [BUS_W-1:0]  exp;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bus_pg();
`ifdef VGA_BUF_DOUBLE_EN
        return page_exp ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    function automatic int vid_pg();
`ifdef VGA_BUF_DOUBLE_EN
        return page_exp ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus-read scoreboard: every r_valid_o cycle consumes one expected value.
    always @(negedge clk) begin
        if (bus_if.r_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected actual=valid required=no_valid at %0t", $time);
            end else begin
                check("rd_data", bus_if.r_data_o, exp_q.pop_front());
            end
        end
    end

    task automatic model_clear();
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < DEPTH; a++)
                model[p][a] = '0;
        page_exp = 1'b0;
        pend_exp = 1'b0;
    endtask

    task automatic wr(input int addr, input logic [DATA_W-1:0] d, input logic [3:0] s);
        int p;
        p = bus_pg();
        bus_if.wr_en_i  = 1'b1;
        bus_if.w_addr_i = ADDR_W'(addr);
        bus_if.din_i    = d;
        bus_if.w_strb_i = s;
        tick();
        bus_if.wr_en_i  = 1'b0;
        if (addr < DEPTH)
            for (int b = 0; b < DATA_W; b++)
                if (s[b/8]) model[p][addr][b] = d[b];
    endtask

    task automatic bus_read(input int addr, input logic [BUS_W-1:0] e);
        bus_if.r_req_i  = 1'b1;
        bus_if.r_addr_i = ADDR_W'(addr);
        exp_q.push_back(e);
        tick();
        bus_if.r_req_i  = 1'b0;
        check("rd_valid", 32'(bus_if.r_valid_o), 32'd1);
        tick();
        check("rd_pulse", 32'(bus_if.r_valid_o), 32'd0);
        check("rd_hold", bus_if.r_data_o, e);
    endtask

    task automatic vid(input int addr);
        logic [DATA_W-1:0] e;
        vr_addr = ADDR_W'(addr);
        e = (addr < DEPTH) ? model[vid_pg()][addr] : '0;
        tick();
        check("vid", 32'(dout), 32'(e));
    endtask

    task automatic swap(input logic s, input logic f);
        swap_req    = s;
        frame_start = f;
        tick();
        swap_req    = 1'b0;
        frame_start = 1'b0;
`ifdef VGA_BUF_DOUBLE_EN
        if (f && (pend_exp || s)) begin
            page_exp = ~page_exp;
            pend_exp = 1'b0;
        end else if (s) begin
            pend_exp = 1'b1;
        end
`endif
        check("page", 32'(page), 32'(page_exp));
        check("pending", 32'(swap_pending), 32'(pend_exp));
    endtask

    // Counts cycles until busy_o falls; pokes a write, a bus read and the video port mid-clear.
    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 2000) begin
            bus_if.wr_en_i  = (n == 100);
            bus_if.w_addr_i = ADDR_W'(5);
            bus_if.din_i    = 28'h0000055;
            bus_if.w_strb_i = 4'hF;
            bus_if.r_req_i  = (n == 200);
            bus_if.r_addr_i = ADDR_W'(599);
            if (n == 200) exp_q.push_back('0);
            if (n == 300) check("busy_dout", 32'(dout), 32'd0);
            tick();
            n++;
        end
        bus_if.wr_en_i = 1'b0;
        bus_if.r_req_i = 1'b0;
    endtask

    initial begin
        int n;
        int p;
        logic [DATA_W-1:0] old_b, old_v;

        vt[0] = '{4,   28'hBBBBBBB, 4'b1111, 4,    32'h0BBBBBBB};
        vt[1] = '{4,   28'h4444444, 4'b0000, 4,    32'h0BBBBBBB};
        vt[2] = '{4,   28'h4444444, 4'b0101, 4,    32'h0B44BB44};
        vt[3] = '{4,   28'hFFFFFFF, 4'b1000, 4,    32'h0F44BB44};
        vt[4] = '{600, 28'h1234567, 4'b1111, 700,  32'h00000000};
        vt[5] = '{600, 28'h1234567, 4'b1111, 88,   32'h00000058};
        vt[6] = '{1023, 28'hAAAAAAA, 4'b1111, 1023, 32'h00000000};

        bus_if.wr_en_i = 1'b0; bus_if.w_addr_i = '0; bus_if.w_strb_i = '0; bus_if.din_i = '0;
        bus_if.r_req_i = 1'b0; bus_if.r_addr_i = '0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rdata", bus_if.r_data_o, 32'd0);
        check("rst_rvalid", 32'(bus_if.r_valid_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_page", 32'(page), 32'd0);
        check("rst_pend", 32'(swap_pending), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        model_clear();
        vr_addr = ADDR_W'(599);
        wait_clear(n);
        check("clear_cycles", 32'(n), 32'd600);
        check("idle_state", 32'(dbg_state), 32'd1);
        bus_read(5, 32'd0);

        for (int a = 0; a < DEPTH; a++) vid(a);

        for (int a = 0; a < DEPTH; a++) wr(a, DATA_W'(a), 4'hF);
        for (int a = 0; a < DEPTH; a++) vid(a);
        bus_read(599, 32'h00000257);

        for (int i = 0; i < 7; i++) begin
            wr(vt[i].addr, vt[i].data, vt[i].strb);
            bus_read(vt[i].rd_addr, vt[i].exp);
        end
        vid(600);
        vid(1023);
        vid(88);

        // Write and reads to the same address on one edge return the old contents.
        p = bus_pg();
        old_b = model[p][20];
        old_v = model[vid_pg()][20];
        bus_if.wr_en_i = 1'b1; bus_if.w_addr_i = ADDR_W'(20);
        bus_if.din_i = 28'hABCDEF0; bus_if.w_strb_i = 4'hF;
        bus_if.r_req_i = 1'b1; bus_if.r_addr_i = ADDR_W'(20);
        vr_addr = ADDR_W'(20);
        exp_q.push_back(32'(old_b));
        tick();
        bus_if.wr_en_i = 1'b0;
        bus_if.r_req_i = 1'b0;
        check("same_vid", 32'(dout), 32'(old_v));
        check("same_rvalid", 32'(bus_if.r_valid_o), 32'd1);
        model[p][20] = 28'hABCDEF0;
        tick();
        bus_read(20, 32'h0ABCDEF0);

        wr(10, 28'h0000123, 4'hF);
        vid(10);
        swap(1'b1, 1'b0);
        swap(1'b0, 1'b1);
        vid(10);
        swap(1'b0, 1'b1);
        swap(1'b1, 1'b1);
        swap(1'b1, 1'b1);
        vid(10);

        // Reset mid-operation acts immediately, then a second reset mid-clear restarts the sweep.
        vr_addr = ADDR_W'(599);
        tick();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_rdata", bus_if.r_data_o, 32'd0);
        check("mid_rst_rvalid", 32'(bus_if.r_valid_o), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_page", 32'(page), 32'd0);
        check("mid_rst_pend", 32'(swap_pending), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        model_clear();
        repeat (300) tick();
        check("busy_at_300", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (2) tick();
        check("busy_in_rst", 32'(busy), 32'd1);
        rst = 1'b0;
        wait_clear(n);
        check("restart_cycles", 32'(n), 32'd600);
        bus_read(5, 32'd0);
        bus_read(599, 32'd0);
        vid(599);
        vid(4);

        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_tile_buffer.md
VGA_TILE_BUFFER -- requirements
Module: vga_tile_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 28, meaning tile entry width in bits (1..BUS_W).
REQ-002 SHALL have parameter DEPTH, default 600, meaning number of tile entries per page.
REQ-003 SHALL have parameter ADDR_W, default 10, meaning address width (2^ADDR_W >= DEPTH).
REQ-004 SHALL have parameter BUS_W, default 32, meaning bus data width; STRB_W = BUS_W/8.
REQ-005 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-006 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port wr_en_i  in  1  bus write enable.
REQ-008 SHALL have port w_addr_i  in  ADDR_W  bus write address.
REQ-009 SHALL have port w_strb_i  in  STRB_W  byte write strobes.
REQ-010 SHALL have port din_i  in  DATA_W  write data.
REQ-011 SHALL have port r_req_i  in  1  bus read request.
REQ-012 SHALL have port r_addr_i  in  ADDR_W  bus read address.
REQ-013 SHALL have port r_data_o  out  BUS_W  bus read data, zero-extended.
REQ-014 SHALL have port r_valid_o  out  1  bus read data valid pulse.
REQ-015 SHALL have port vr_addr_i  in  ADDR_W  video read address.
REQ-016 SHALL have port dout_o  out  DATA_W  video read data.
REQ-017 SHALL have ports swap_req_i (in, 1), frame_start_i (in, 1), swap_pending_o (out, 1), page_o (out, 1) and busy_o (out, 1), used for page swap and clear status.

Function
REQ-018 Video read: dout_o SHALL equal the entry at the vr_addr_i sampled on the previous rising edge (1-cycle latency).
REQ-019 Bus read: r_req_i high at edge N SHALL give r_valid_o high for exactly the cycle after N, with r_data_o = entry[r_addr_i] zero-extended. r_data_o SHALL hold its value until the next request.
REQ-020 Write: when wr_en_i is high and busy_o is low at an edge, for each k with w_strb_i[k]=1, entry bits [8k+7:8k] clipped to DATA_W SHALL take the din_i bits. Strobe bits at or above ceil(DATA_W/8) SHALL be ignored.
REQ-021 Addresses >= DEPTH: writes SHALL be discarded. Video and bus reads SHALL return 0.
REQ-022 Same-address write and read on the same edge: the read SHALL return the pre-write value.
REQ-023 Clear FSM, states CLEAR and IDLE: CLEAR SHALL write 0 to entries 0..DEPTH-1 (all pages) at one per cycle, then go to IDLE. busy_o SHALL be 1 exactly while in CLEAR.
REQ-024 While busy_o is 1: writes SHALL be ignored, dout_o SHALL be 0, and bus reads SHALL still pulse r_valid_o with r_data_o = 0.
REQ-025 swap_req_i high SHALL set swap_pending_o. frame_start_i high while pending, or together with swap_req_i, SHALL toggle page_o and clear swap_pending_o on that edge. frame_start_i without pending SHALL have no effect.

Reset
REQ-026 rst_i high SHALL immediately force dout_o=0, r_data_o=0, r_valid_o=0, page_o=0, swap_pending_o=0, busy_o=1 and state CLEAR with clear address 0.
REQ-027 Reset asserted mid-clear or mid-operation SHALL restart the clear from address 0. busy_o SHALL fall DEPTH cycles after rst_i release.

Configuration
REQ-028 With VGA_BUF_DOUBLE_EN defined: two DEPTH-entry pages SHALL exist. Video reads SHALL use page page_o, and bus reads and writes SHALL use page !page_o.
REQ-029 Without VGA_BUF_DOUBLE_EN: one page SHALL exist, shared by video and bus. swap_req_i and frame_start_i SHALL be ignored, and page_o and swap_pending_o SHALL be constant 0.

Verification
REQ-030 Reset, wait for busy_o=0 (600 cycles), sweep vr_addr_i 0..599 -> dout_o = 0 at every address.
REQ-031 Write din_i=addr with strb 1111 at addresses 0..599, then (single-page build) sweep vr_addr_i -> dout_o = addr one cycle later. r_req_i at addr 599 -> r_valid_o next cycle with r_data_o = 0x00000257.
REQ-032 Strobes at addr 4: write 0xBBBBBBB with strb 1111, then 0x4444444 with strb 0000 -> 0xBBBBBBB; then 0x4444444 with strb 0101 -> 0xB44BB44; then 0xFFFFFFF with strb 1000 -> 0xF44BB44.
REQ-033 Write 0x1234567 to addr 600 and read addr 700 -> no entry changes, and r_data_o = 0 with r_valid_o pulsing.
REQ-034 Double-page build: write 0x123 to addr 10 -> video dout_o = 0 at addr 10. Then swap_req_i, then frame_start_i -> page_o = 1 and swap_pending_o = 0 next cycle, and dout_o = 0x123 at addr 10.
REQ-035 Assert rst_i at clear cycle 300 for 2 cycles -> busy_o stays 1 and falls exactly 600 cycles after release. A write attempted at cycle 100 of the clear is lost.
